// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: four-requester round-robin arbiter with grant hold and hold-time preemption.
// Define ROUND_ROBIN_ARBITER_LOCK_EN to add a lock input that suppresses timeout preemption.
module round_robin_arbiter #(
    parameter int MAX_HOLD  = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    input  logic       lock,
`endif
    input  logic       req_0,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       req_3,
    output logic       gnt_0,
    output logic       gnt_1,
    output logic       gnt_2,
    output logic       gnt_3,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       preempt
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t               state, state_nx;
    logic [1:0]           last_owner, last_owner_nx, win, idx;
    logic [CNT_WIDTH-1:0] hold_cnt, hold_cnt_nx;
    logic [3:0]           gnt, gnt_nx, req, cand;
    logic                 preempt_nx, found, owner_req, others, timeout, locked;

    assign req = {req_3, req_2, req_1, req_0};
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    assign locked = lock;
`else
    assign locked = 1'b0;
`endif
    assign owner_req = req[last_owner];
    // While granted the owner is excluded, so the same search serves release and preemption
    assign cand      = (state == GRANT) ? (req & ~(4'b0001 << last_owner)) : req;
    assign others    = |cand;
    assign timeout   = (MAX_HOLD != 0) && (hold_cnt == CNT_WIDTH'(MAX_HOLD - 1)) && !locked;

    always_comb begin
        win   = last_owner;
        found = 1'b0;
        idx   = last_owner;
        for (int i = 1; i <= 4; i++) begin
            idx = last_owner + 2'(i);
            if (!found && cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        last_owner_nx = last_owner;
        hold_cnt_nx   = hold_cnt;
        gnt_nx        = gnt;
        preempt_nx    = 1'b0;
        if (state == IDLE || !owner_req || (others && timeout)) begin
            hold_cnt_nx   = '0;
            state_nx      = found ? GRANT : IDLE;
            gnt_nx        = found ? (4'b0001 << win) : 4'b0000;
            last_owner_nx = found ? win : last_owner;
            preempt_nx    = found && (state == GRANT) && owner_req;
        end else if (!locked) begin
            hold_cnt_nx = !others ? '0 :
                          (hold_cnt < CNT_WIDTH'(MAX_HOLD)) ? hold_cnt + 1'b1 : hold_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 2'd3;
            hold_cnt   <= '0;
            gnt        <= 4'b0000;
            preempt    <= 1'b0;
        end else begin
            state      <= state_nx;
            last_owner <= last_owner_nx;
            hold_cnt   <= hold_cnt_nx;
            gnt        <= gnt_nx;
            preempt    <= preempt_nx;
        end
    end

    assign {gnt_3, gnt_2, gnt_1, gnt_0} = gnt;
    assign busy   = (state == GRANT);
    assign gnt_id = busy ? last_owner : 2'd0;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: vector table, directed corner sequences and random traffic against a reference model.
module tb_round_robin_arbiter;
    localparam int MAXH = 4;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       pre;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lock = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       g0, g1, g2, g3, busy, preempt;
    logic [1:0] gnt_id;
    logic [3:0] gnt;
    int         checks = 0;
    int         failures = 0;
    int         m_owner = -1;
    int         m_last = 3;
    int         m_hold = 0;
    int         m_pre = 0;
    vec_t       tbl [17];

    assign gnt = {g3, g2, g1, g0};

    always #5 clk = ~clk;

    round_robin_arbiter #(.MAX_HOLD(MAXH), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
        .lock(lock),
`endif
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]),
        .gnt_0(g0), .gnt_1(g1), .gnt_2(g2), .gnt_3(g3),
        .gnt_id(gnt_id), .busy(busy), .preempt(preempt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First requester found walking forward from 'from', looking n positions ahead
    function automatic int pick(input logic [3:0] r, input int from, input int n);
        for (int k = 1; k <= n; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_pre   = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic lk);
        m_pre = 0;
        if (m_owner >= 0 && r[m_owner]) begin
            if (!lk) begin
                if ((r & ~(4'b0001 << m_owner)) == 4'b0000) m_hold = 0;
                else if (m_hold == MAXH - 1) begin
                    m_owner = pick(r, m_owner, 3);
                    m_last  = m_owner;
                    m_hold  = 0;
                    m_pre   = 1;
                end else m_hold++;
            end
        end else begin
            m_owner = pick(r, m_last, 4);
            if (m_owner >= 0) m_last = m_owner;
            m_hold = 0;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_gnt"}, int'(gnt), m_owner >= 0 ? (1 << m_owner) : 0);
        chk({tag, "_id"}, int'(gnt_id), m_owner >= 0 ? m_owner : 0);
        chk({tag, "_busy"}, int'(busy), m_owner >= 0 ? 1 : 0);
        chk({tag, "_pre"}, int'(preempt), m_pre);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(req, lock);
        @(negedge clk);
        chk_model(tag);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req  = 4'b0000;
        lock = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_id", int'(gnt_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pre", int'(preempt), 0);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seq [5];
        int prev, run, n, cur;
        bit seen;

        tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[7]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[9]  = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[12] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[13] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[14] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[15] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            req = tbl[i].req;
            @(posedge clk);
            model_edge(req, lock);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            chk($sformatf("tbl%0d_id", i), int'(gnt_id), int'(tbl[i].id));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_pre", i), int'(preempt), int'(tbl[i].pre));
        end

        // Everyone requesting; each owner drops its request after three granted cycles
        do_reset();
        req  = 4'b1111;
        prev = -1;
        run  = 0;
        n    = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            step("rr");
            chk("rr_busy", int'(busy), 1);
            chk("rr_pre", int'(preempt), 0);
            req = 4'b1111;
            cur = int'(gnt_id);
            if (cur != prev) begin
                seq[n] = cur;
                n++;
                run  = 1;
                prev = cur;
            end else run++;
            if (run == 3) req[cur] = 1'b0;
        end
        chk("rr_handoffs", n, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), seq[i], i % 4);

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 4'b0100;
        step("mid");
        step("mid");
        #2 rst = 1'b0;
        #1;
        chk("async_gnt", int'(gnt), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_id", int'(gnt_id), 0);
        model_reset();
        req = 4'b1010;
        @(negedge clk);
        rst = 1'b1;
        step("post_rst");
        chk("post_rst_first", int'(gnt), 4'b0010);

`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
        do_reset();
        lock = 1'b1;
        req  = 4'b0001;
        step("lock");
        req = 4'b0011;
        for (int c = 0; c < 22; c++) begin
            step("lock_hold");
            chk("lock_owner", int'(gnt), 4'b0001);
        end
        lock = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            step("unlock");
            seen = preempt;
        end
        chk("unlock_preempt", int'(seen), 1);
        chk("unlock_gnt", int'(gnt), 4'b0010);
`endif

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(4) == 0) req[b] = ~req[b];
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
            if ($urandom_range(9) == 0) lock = ~lock;
`endif
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
